// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin sharing of one combinational ALU between two
//            valid/ready requesters, with a registered, id-tagged response.
//            Define ALU_ARB_PERF_EN to add per-requester accept counters.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int W  = 32,
    parameter int FW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [W-1:0]  req0_a,
    input  logic [W-1:0]  req0_b,
    input  logic [FW-1:0] req0_f,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [W-1:0]  req1_a,
    input  logic [W-1:0]  req1_b,
    input  logic [FW-1:0] req1_f,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [FW-1:0] alu_f,
    input  logic [W-1:0]  alu_y,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [W-1:0]  rsp_y
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]   perf_cnt0,
    output logic [31:0]   perf_cnt1
`endif
);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RESP = 1'b1;

    logic [0:0]   r_state;
    logic         r_last_gnt;
    logic         r_rsp_id;
    logic [W-1:0] r_rsp_y;

    logic w_can_accept;
    logic w_gnt_vld;
    logic w_gnt_id;
    logic w_accept;

    always_comb begin
        w_can_accept = (r_state == c_ST_IDLE) | rsp_ready;
        w_gnt_vld    = req0_valid | req1_valid;
        // On contention the requester not served last wins.
        w_gnt_id     = (req0_valid & req1_valid) ? ~r_last_gnt : req1_valid;
        w_accept     = w_can_accept & w_gnt_vld;
    end

    assign req0_ready = w_accept & ~w_gnt_id;
    assign req1_ready = w_accept &  w_gnt_id;

    always_comb begin
        alu_a = '0;
        alu_b = '0;
        alu_f = '0;
        if (w_accept) begin
            if (w_gnt_id) begin
                alu_a = req1_a;
                alu_b = req1_b;
                alu_f = req1_f;
            end else begin
                alu_a = req0_a;
                alu_b = req0_b;
                alu_f = req0_f;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_last_gnt <= 1'b1;
            r_rsp_id   <= 1'b0;
            r_rsp_y    <= '0;
        end else if (w_accept) begin
            r_state    <= c_ST_RESP;
            r_last_gnt <= w_gnt_id;
            r_rsp_id   <= w_gnt_id;
            r_rsp_y    <= alu_y;
        end else if (rsp_ready) begin
            r_state    <= c_ST_IDLE;
        end
    end

    assign rsp_valid = (r_state == c_ST_RESP);
    assign rsp_id    = r_rsp_id;
    assign rsp_y     = r_rsp_y;

`ifdef ALU_ARB_PERF_EN
    logic [31:0] r_perf_cnt0;
    logic [31:0] r_perf_cnt1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_cnt0 <= '0;
            r_perf_cnt1 <= '0;
        end else begin
            if (req0_ready && (r_perf_cnt0 != 32'hFFFF_FFFF)) begin
                r_perf_cnt0 <= r_perf_cnt0 + 32'd1;
            end
            if (req1_ready && (r_perf_cnt1 != 32'hFFFF_FFFF)) begin
                r_perf_cnt1 <= r_perf_cnt1 + 32'd1;
            end
        end
    end

    assign perf_cnt0 = r_perf_cnt0;
    assign perf_cnt1 = r_perf_cnt1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Self-checking bench for alu_arbiter: directed vector table,
//            reset-in-RESP sequence and randomized run against a reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
    } op_t;

    typedef struct packed {
        logic        rst;
        logic        v0;
        op_t         o0;
        logic        v1;
        op_t         o1;
        logic        rr;
        logic        er0;
        logic        er1;
        logic        erv;
        logic        eid;
        logic [31:0] ey;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_f, req1_f;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [2:0]  alu_f;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_y;
`ifdef ALU_ARB_PERF_EN
    logic [31:0] perf_cnt0, perf_cnt1;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.W(32), .FW(3)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y)
`ifdef ALU_ARB_PERF_EN
        , .perf_cnt0(perf_cnt0), .perf_cnt1(perf_cnt1)
`endif
    );

    function automatic logic [31:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [2:0] f);
        case (f)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd3:    return a ^ b;
            3'd4:    return ~(a | b);
            3'd5:    return a << b[4:0];
            3'd6:    return a - b;
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // The shared ALU seen by the arbiter.
    always_comb alu_y = alu_ref(alu_a, alu_b, alu_f);

    // Requester protocol: a pending (valid, not ready) op must stay put.
    logic p0_prev = 1'b0, p1_prev = 1'b0;
    op_t  d0_prev, d1_prev;
    always @(posedge clk) begin
        if (!reset && p0_prev)
            assert (req0_valid && (op_t'{req0_a, req0_b, req0_f} == d0_prev))
                else $error("requester 0 dropped or changed a pending op");
        if (!reset && p1_prev)
            assert (req1_valid && (op_t'{req1_a, req1_b, req1_f} == d1_prev))
                else $error("requester 1 dropped or changed a pending op");
        p0_prev <= req0_valid && !req0_ready;
        p1_prev <= req1_valid && !req1_ready;
        d0_prev <= op_t'{req0_a, req0_b, req0_f};
        d1_prev <= op_t'{req1_a, req1_b, req1_f};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input op_t o0, input logic v1, input op_t o1, input logic rr);
        req0_valid = v0; req0_a = o0.a; req0_b = o0.b; req0_f = o0.f;
        req1_valid = v1; req1_a = o1.a; req1_b = o1.b; req1_f = o1.f;
        rsp_ready  = rr;
    endtask

    function automatic vec_t mk(logic rst, logic v0, op_t o0, logic v1, op_t o1, logic rr,
                                logic er0, logic er1, logic erv, logic eid, logic [31:0] ey);
        return '{rst, v0, o0, v1, o1, rr, er0, er1, erv, eid, ey};
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        o.b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        o.f = 3'($urandom_range(0, 7));
        return o;
    endfunction

    op_t op_z = '{32'd0, 32'd0, 3'd0};
    op_t op_a = '{32'd5, 32'd7, 3'b010};
    op_t op_p = '{32'd10, 32'd3, 3'b110};
    op_t op_q = '{32'd2, 32'd9, 3'b111};
    op_t op_r = '{32'h0000_00F0, 32'h0000_000F, 3'b001};
    op_t op_s = '{32'hFFFF_0000, 32'h00FF_FF00, 3'b000};

    vec_t tbl[$];

    initial begin
        int   acc0, acc1, w;
        logic m_hold, m_id, m_last, p0, p1, rr;
        logic [31:0] m_y;
        op_t  op0, op1, ea;

        reset = 1'b1;
        drive(1'b0, op_z, 1'b0, op_z, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // rst v0 o0 v1 o1 rr | r0 r1 rv id y
        tbl.push_back(mk(0, 1, op_a, 0, op_z, 1, 1, 0, 0, 0, 32'd0));
        tbl.push_back(mk(0, 0, op_z, 0, op_z, 1, 0, 0, 1, 0, 32'd12));
        tbl.push_back(mk(1, 0, op_z, 0, op_z, 1, 0, 0, 0, 0, 32'd0));
        tbl.push_back(mk(0, 1, op_p, 1, op_q, 1, 1, 0, 0, 0, 32'd0));
        tbl.push_back(mk(0, 1, op_p, 1, op_q, 1, 0, 1, 1, 0, 32'd7));
        tbl.push_back(mk(0, 1, op_p, 1, op_q, 1, 1, 0, 1, 1, 32'd1));
        tbl.push_back(mk(0, 1, op_p, 1, op_q, 1, 0, 1, 1, 0, 32'd7));
        tbl.push_back(mk(0, 1, op_p, 0, op_z, 1, 1, 0, 1, 1, 32'd1));
        tbl.push_back(mk(0, 0, op_z, 1, op_r, 1, 0, 1, 1, 0, 32'd7));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 1, op_p, 1, op_r, 0, 0, 0, 1, 1, 32'hFF));
        tbl.push_back(mk(0, 1, op_p, 1, op_r, 1, 1, 0, 1, 1, 32'hFF));
        tbl.push_back(mk(0, 0, op_z, 1, op_r, 1, 0, 1, 1, 0, 32'd7));
        tbl.push_back(mk(0, 0, op_z, 0, op_z, 1, 0, 0, 1, 1, 32'hFF));
        tbl.push_back(mk(0, 0, op_z, 1, op_s, 1, 0, 1, 0, 0, 32'd0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 0, op_z, 1, op_s, 1, 0, 1, 1, 1, 32'h00FF_0000));
        tbl.push_back(mk(0, 1, op_p, 1, op_s, 1, 1, 0, 1, 1, 32'h00FF_0000));
        tbl.push_back(mk(0, 0, op_z, 1, op_s, 1, 0, 1, 1, 0, 32'd7));
        tbl.push_back(mk(0, 0, op_z, 0, op_z, 1, 0, 0, 1, 1, 32'h00FF_0000));
        tbl.push_back(mk(0, 0, op_z, 0, op_z, 1, 0, 0, 0, 0, 32'd0));

        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("reset rsp_y", rsp_y, 32'd0);

        acc0 = 0; acc1 = 0;
        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            drive(tbl[i].v0, tbl[i].o0, tbl[i].v1, tbl[i].o1, tbl[i].rr);
            #2;
            if (!tbl[i].rst) begin
                ea = tbl[i].er0 ? tbl[i].o0 : (tbl[i].er1 ? tbl[i].o1 : op_z);
                chk($sformatf("tbl%0d req0_ready", i), {31'd0, req0_ready}, {31'd0, tbl[i].er0});
                chk($sformatf("tbl%0d req1_ready", i), {31'd0, req1_ready}, {31'd0, tbl[i].er1});
                chk($sformatf("tbl%0d alu_a", i), alu_a, ea.a);
                chk($sformatf("tbl%0d alu_b", i), alu_b, ea.b);
                chk($sformatf("tbl%0d alu_f", i), {29'd0, alu_f}, {29'd0, ea.f});
                chk($sformatf("tbl%0d rsp_valid", i), {31'd0, rsp_valid}, {31'd0, tbl[i].erv});
                if (tbl[i].erv) begin
                    chk($sformatf("tbl%0d rsp_id", i), {31'd0, rsp_id}, {31'd0, tbl[i].eid});
                    chk($sformatf("tbl%0d rsp_y", i), rsp_y, tbl[i].ey);
                end
                acc0 += int'(tbl[i].er0);
                acc1 += int'(tbl[i].er1);
            end else begin
                acc0 = 0; acc1 = 0;
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
`ifdef ALU_ARB_PERF_EN
        chk("perf_cnt0 after table", perf_cnt0, 32'(acc0));
        chk("perf_cnt1 after table", perf_cnt1, 32'(acc1));
`endif

        // Reset while a result is held under backpressure.
        drive(1'b1, op_a, 1'b0, op_z, 1'b0);
        #2 chk("rst-seq accept", {31'd0, req0_ready}, 32'd1);
        @(posedge clk); #1;
        drive(1'b1, op_p, 1'b1, op_q, 1'b0);
        #2;
        chk("rst-seq held y", rsp_y, 32'd12);
        chk("rst-seq stalled ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst-seq stalled ready1", {31'd0, req1_ready}, 32'd0);
        chk("rst-seq stalled alu_a", alu_a, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #2;
        chk("rst-seq rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst-seq rsp_y", rsp_y, 32'd0);
        chk("rst-seq ready0 first", {31'd0, req0_ready}, 32'd1);
        chk("rst-seq ready1 first", {31'd0, req1_ready}, 32'd0);
`ifdef ALU_ARB_PERF_EN
        chk("perf_cnt0 after reset", perf_cnt0, 32'd0);
        chk("perf_cnt1 after reset", perf_cnt1, 32'd0);
`endif
        @(posedge clk); #1;
        drive(1'b0, op_z, 1'b1, op_q, 1'b1);
        #2;
        chk("rst-seq rsp y", rsp_y, 32'd7);
        chk("rst-seq ready1 next", {31'd0, req1_ready}, 32'd1);
        @(posedge clk); #1;

        // Randomized run against a transaction-level model.
        reset = 1'b1;
        drive(1'b0, op_z, 1'b0, op_z, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        m_hold = 1'b0; m_id = 1'b0; m_y = '0; m_last = 1'b1;
        p0 = 1'b0; p1 = 1'b0; op0 = op_z; op1 = op_z;
        acc0 = 0; acc1 = 0;
        for (int c = 0; c < 400; c++) begin
            if (!p0 && $urandom_range(0, 1) == 1) begin p0 = 1'b1; op0 = rand_op(); end
            if (!p1 && $urandom_range(0, 1) == 1) begin p1 = 1'b1; op1 = rand_op(); end
            rr = ($urandom_range(0, 3) != 0);
            drive(p0, op0, p1, op1, rr);
            #2;
            w = -1;
            if (!m_hold || rr) begin
                if (p0 && p1) w = m_last ? 0 : 1;
                else if (p0)  w = 0;
                else if (p1)  w = 1;
            end
            ea = (w == 0) ? op0 : ((w == 1) ? op1 : op_z);
            chk("rnd req0_ready", {31'd0, req0_ready}, {31'd0, w == 0});
            chk("rnd req1_ready", {31'd0, req1_ready}, {31'd0, w == 1});
            chk("rnd alu_a", alu_a, ea.a);
            chk("rnd alu_b", alu_b, ea.b);
            chk("rnd alu_f", {29'd0, alu_f}, {29'd0, ea.f});
            chk("rnd rsp_valid", {31'd0, rsp_valid}, {31'd0, m_hold});
            if (m_hold) begin
                chk("rnd rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
                chk("rnd rsp_y", rsp_y, m_y);
            end
            @(posedge clk); #1;
            if (w >= 0) begin
                m_hold = 1'b1;
                m_id   = (w == 1);
                m_last = (w == 1);
                m_y    = alu_ref(ea.a, ea.b, ea.f);
                if (w == 0) begin p0 = 1'b0; acc0++; end
                else        begin p1 = 1'b0; acc1++; end
            end else if (rr) begin
                m_hold = 1'b0;
            end
        end
`ifdef ALU_ARB_PERF_EN
        chk("perf_cnt0 random", perf_cnt0, 32'(acc0));
        chk("perf_cnt1 random", perf_cnt1, 32'(acc1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
